// File: rtl/lc3_reg_file.sv
// LC-3 architectural register file (R0..R7) with N/Z/P condition-code flags.
// Reads are combinational with no write-through; writes and CC updates happen on the rising clock edge.
module lc3_reg_file #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus,
  input  logic [15:0]      ir,
  input  logic             ld_reg,
  input  logic             ld_cc,
  input  logic [1:0]       dr_mux,
  input  logic [1:0]       sr1_mux,
  output logic [WIDTH-1:0] sr1_out,
  output logic [WIDTH-1:0] sr2_out,
  output logic             n,
  output logic             z,
  output logic             p
);

  localparam int unsigned SelW = $clog2(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [2:0]       nzp_q, nzp_d;

  logic [SelW-1:0]  dest;
  logic             dest_vld;
  logic [SelW-1:0]  sr1_sel;
  logic [SelW-1:0]  sr2_sel;

  // Destination decode; dr_mux=3 is reserved and suppresses the write.
  always_comb begin
    dest     = '0;
    dest_vld = 1'b1;
    unique case (dr_mux)
      2'd0: dest = SelW'(ir[11:9]);
      2'd1: dest = SelW'(NREGS - 1);
      2'd2: dest = SelW'(NREGS - 2);
      default: begin
        dest     = '0;
        dest_vld = 1'b0;
      end
    endcase
  end

  // SR1 decode; the reserved encoding reads R0.
  always_comb begin
    sr1_sel = '0;
    unique case (sr1_mux)
      2'd0:    sr1_sel = SelW'(ir[11:9]);
      2'd1:    sr1_sel = SelW'(ir[8:6]);
      2'd2:    sr1_sel = SelW'(NREGS - 2);
      default: sr1_sel = '0;
    endcase
  end

  assign sr2_sel = SelW'(ir[2:0]);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (ld_reg && dest_vld) begin
      regs_d[dest] = bus;
    end
  end

  always_comb begin
    nzp_d = nzp_q;
    if (ld_cc) begin
      nzp_d[2] = bus[WIDTH-1];
      nzp_d[1] = (bus == '0);
      nzp_d[0] = !bus[WIDTH-1] && (bus != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      nzp_q <= 3'b010;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      nzp_q <= nzp_d;
    end
  end

  assign sr1_out = regs_q[sr1_sel];
  assign sr2_out = regs_q[sr2_sel];
  assign n       = nzp_q[2];
  assign z       = nzp_q[1];
  assign p       = nzp_q[0];

endmodule

// File: tb/tb_lc3_reg_file.sv
// Directed bench for lc3_reg_file: reset, writes through every dr_mux path, read timing and CC flags.
module tb_lc3_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus;
  logic [15:0] ir;
  logic        ld_reg;
  logic        ld_cc;
  logic [1:0]  dr_mux;
  logic [1:0]  sr1_mux;
  logic [15:0] sr1_out;
  logic [15:0] sr2_out;
  logic        n, z, p;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_regs [8];
  logic [15:0] shifter_in;

  lc3_reg_file #(.WIDTH(16), .NREGS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ir      (ir),
    .ld_reg  (ld_reg),
    .ld_cc   (ld_cc),
    .dr_mux  (dr_mux),
    .sr1_mux (sr1_mux),
    .sr1_out (sr1_out),
    .sr2_out (sr2_out),
    .n       (n),
    .z       (z),
    .p       (p)
  );

  // Shifter operand input is wired straight from SR1.
  assign shifter_in = sr1_out;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reads register k through sr1_mux=1 (ir[8:6]) and also via sr2 (ir[2:0]).
  task automatic check_reg(input string tag, input int k, input logic [15:0] exp);
    sr1_mux  = 2'd1;
    ir[8:6]  = 3'(k);
    ir[2:0]  = 3'(k);
    #1;
    check({tag, "_sr1"}, sr1_out, exp);
    check({tag, "_sr2"}, sr2_out, exp);
  endtask

  initial begin
    rst     = 1'b1;
    bus     = 16'hFFFF;
    ir      = 16'h0000;
    ld_reg  = 1'b1;
    ld_cc   = 1'b1;
    dr_mux  = 2'd0;
    sr1_mux = 2'd0;

    // 1: reset wins over loads
    step();
    step();
    rst    = 1'b0;
    ld_reg = 1'b0;
    ld_cc  = 1'b0;
    #1;
    check("rst_nzp", {13'd0, n, z, p}, 16'h0002);
    for (int k = 0; k < 8; k++) check_reg($sformatf("rst_r%0d", k), k, 16'h0000);

    // 2: write each register via ir[11:9]
    for (int k = 0; k < 8; k++) begin
      ir[11:9] = 3'(k);
      dr_mux   = 2'd0;
      ld_reg   = 1'b1;
      bus      = 16'h1000 + 16'(k);
      exp_regs[k] = 16'h1000 + 16'(k);
      step();
    end
    ld_reg = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sr1_mux  = 2'd0;
      ir[11:9] = 3'(k);
      ir[2:0]  = 3'(k);
      #1;
      check($sformatf("wr_sr1_r%0d", k), sr1_out, exp_regs[k]);
      check($sformatf("wr_sr2_r%0d", k), sr2_out, exp_regs[k]);
    end

    // 3: no write-through; new value visible next cycle
    step();
    ir[11:9] = 3'd3;
    sr1_mux  = 2'd0;
    dr_mux   = 2'd0;
    bus      = 16'hA5A5;
    ld_reg   = 1'b1;
    #1;
    check("r3_old", sr1_out, 16'h1003);
    check("r3_shift_old", shifter_in, 16'h1003);
    step();
    ld_reg = 1'b0;
    exp_regs[3] = 16'hA5A5;
    #1;
    check("r3_new", sr1_out, 16'hA5A5);
    check("r3_shift_new", shifter_in, 16'hA5A5);

    // 4: condition codes
    ld_cc = 1'b1;
    bus = 16'h8000; step(); check("cc_8000", {13'd0, n, z, p}, 16'h0004);
    bus = 16'h0000; step(); check("cc_0000", {13'd0, n, z, p}, 16'h0002);
    bus = 16'h0001; step(); check("cc_0001", {13'd0, n, z, p}, 16'h0001);
    bus = 16'h7FFF; step(); check("cc_7fff", {13'd0, n, z, p}, 16'h0001);
    ld_cc = 1'b0;
    bus = 16'h8000; step(); check("cc_hold", {13'd0, n, z, p}, 16'h0001);
    check("cc_no_reg_wr_r3", sr1_out, 16'hA5A5);

    // 5: dr_mux R7, R6, reserved
    ld_reg = 1'b1;
    dr_mux = 2'd1; bus = 16'h3000; step();
    exp_regs[7] = 16'h3000;
    dr_mux = 2'd2; bus = 16'hFE00; step();
    exp_regs[6] = 16'hFE00;
    ld_reg = 1'b0;
    sr1_mux = 2'd2;
    #1;
    check("sr1_r6", sr1_out, 16'hFE00);
    check_reg("r7", 7, 16'h3000);
    ld_reg = 1'b1;
    dr_mux = 2'd3; bus = 16'hDEAD; step();
    ld_reg = 1'b0;
    for (int k = 0; k < 8; k++) check_reg($sformatf("dr3_r%0d", k), k, exp_regs[k]);
    sr1_mux = 2'd3;
    #1;
    check("sr1_rsvd_r0", sr1_out, 16'h1000);

    // 6: reset discards a simultaneous load and CC update
    ir[11:9] = 3'd1;
    dr_mux   = 2'd0;
    ld_reg   = 1'b1;
    ld_cc    = 1'b1;
    bus      = 16'h1234;
    rst      = 1'b1;
    step();
    bus = 16'hFFFF;
    step();
    rst    = 1'b0;
    ld_reg = 1'b0;
    ld_cc  = 1'b0;
    #1;
    check("mid_rst_nzp", {13'd0, n, z, p}, 16'h0002);
    check_reg("mid_rst_r1", 1, 16'h0000);
    check_reg("mid_rst_r7", 7, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
